// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_en;
  logic [data_width-1:0]         data_in;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, w_en, data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, w_en, data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Rotating-priority encoder: first set bit of valid_i at or after start_i, wrapping.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    start_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [ID_W-1:0] cand [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign cand[k] = ID_W'((int'(start_i) + k) % NUM_REQ);
  end

  // Scan from the farthest candidate back so the nearest one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_i[cand[k]]) begin
        found_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port.
// Optional per-requester accepted-word counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                              w_clk,
  input  logic                              wrst_n,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*ARB_STAT_W-1:0]     grant_cnt,
`endif
  fifo_wr_arbiter_if.master                 bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]       nxt_ptr, pick_start, pick_idx;
  logic                  pick_found, owner_vld, xfer, rel;
  logic [data_width-1:0] word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign word[i] = bus.req_data[i*data_width +: data_width];
  end

  assign owner_vld  = bus.req_valid[grant_q];
  assign xfer       = (state_q == ARB_LOCK) && owner_vld && !bus.full;
  assign rel        = (state_q == ARB_LOCK) &&
                      (!owner_vld || (xfer && (burst_cnt_q == LAST_CNT)));
  assign nxt_ptr    = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
  // One picker serves both the idle grant and the same-cycle re-pick on release.
  assign pick_start = (state_q == ARB_LOCK) ? nxt_ptr : rr_ptr_q;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid_i (bus.req_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (xfer) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (rel) begin
          rr_ptr_d = nxt_ptr;
          if (pick_found) begin
            grant_d     = pick_idx;
            burst_cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Write-port outputs follow full combinationally; data is zeroed when idle.
  always_comb begin
    bus.w_en      = xfer;
    bus.req_ready = '0;
    bus.data_in   = '0;
    if (xfer) begin
      bus.req_ready[grant_q] = 1'b1;
      bus.data_in            = word[grant_q];
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q == ARB_LOCK);

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][ARB_STAT_W-1:0] stat_q;

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] && (stat_q[i] != '1))
          stat_q[i] <= stat_q[i] + ARB_STAT_W'(1);
      end
    end
  end

  assign grant_cnt = stat_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO. It sits entirely in the write clock domain and shares the single FIFO write port (`w_en`/`data_in`, gated by `full`) between NUM_REQ producers, using valid/ready handshakes. Bursts are locked: a grant holds for up to BURST_MAX consecutive words. The FIFO's `full` flag is honoured combinationally, so the arbiter never issues a write while full.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `data_width`, default 8: word width; matches the FIFO.
- `BURST_MAX`, default 4: maximum words per grant (1..16).

Ports:
- `w_clk`  in  1  write-domain clock; the only clock.
- `wrst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*data_width  requester i occupies bits [i*data_width +: data_width].
- `req_ready`  out  NUM_REQ  one-hot; word accepted this cycle.
- `full`  in  1  FIFO full flag, already in the w_clk domain.
- `w_en`  out  1  FIFO write enable.
- `data_in`  out  data_width  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  current owner.
- `busy`  out  1  high in ARB_LOCK.

## Operation
- State machine states:
  - ARB_IDLE: no owner.
  - ARB_LOCK: `grant_id` owns the port.
- Registered state: `state`, `grant_id`, `burst_cnt` (width $clog2(BURST_MAX+1)), `rr_ptr`.
- Pick function: first index with `req_valid` set, searching cyclically from a start index.
- ARB_IDLE:
  - If any `req_valid`: `grant_id` ← pick(`rr_ptr`), `burst_cnt` ← 0, go to ARB_LOCK.
  - No transfer occurs in ARB_IDLE.
- ARB_LOCK, transfer condition is `req_valid[grant_id] && !full`. When it holds:
  - `w_en`=1, `data_in`=`req_data[grant_id]`, `req_ready[grant_id]`=1.
  - `burst_cnt` increments.
- ARB_LOCK release happens when either:
  - a transfer occurs with `burst_cnt`==BURST_MAX-1, or
  - `req_valid[grant_id]`=0.
- On release:
  - `rr_ptr` ← (`grant_id`+1) mod NUM_REQ.
  - Re-pick from that start index in the same cycle.
  - If a requester is found: load it with `burst_cnt` ← 0 and stay in ARB_LOCK (no bubble). The same owner can be re-picked if it is the only one valid.
  - Otherwise go to ARB_IDLE.
- `full`=1 in ARB_LOCK: no transfer and all `req_ready`=0. Grant and `burst_cnt` hold, and there is no release while owner `req_valid` stays 1.
- Requester rule: once `req_valid` is asserted, data is held stable until `req_ready`. Dropping `req_valid` is treated as release.
- When `w_en`=0, `data_in` is driven 0 (no X propagation into the FIFO).
- Outputs are combinational from state plus inputs. `req_ready` is never asserted while `w_en`=0.

## Timing
- Reset (async, immediate), all cleared:
  - state ARB_IDLE
  - `grant_id`=0, `rr_ptr`=0, `burst_cnt`=0
  - `busy`=0, `w_en`=0, `req_ready`=0, `data_in`=0
- Latency from ARB_IDLE: `req_valid` rising at edge t gives the first `w_en` at cycle t+1.
- Owner switch:
  - Burst exhaustion: zero bubbles.
  - Owner drop: one bubble cycle, the cycle in which the drop is observed.
- Throughput: one word per cycle while the owner is valid and `full`=0.
- `full` rising in the same cycle as a valid word: that word is not accepted. `full` is sampled combinationally, never registered.
- Reset mid-burst: the in-flight word is not written, and `req_ready` drops asynchronously.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output port `grant_cnt`, NUM_REQ*16 bits.
  - One counter per requester, incremented on each accepted word, saturating at 16'hFFFF.
  - Cleared by `wrst_n`.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `fifo_arb_pkg` contains:
  - enum `arb_state_e` {ARB_IDLE, ARB_LOCK}
  - localparam `ARB_STAT_W`=16
- Sub-module `fifo_rr_pick`: combinational rotating-priority encoder.
  - Inputs: valid vector, start index.
  - Outputs: found flag, index.
  - Instantiated once; shared by the ARB_IDLE and release paths.

## Test plan
All scenarios use NUM_REQ=4, BURST_MAX=4, data_width=8.
- Requester 1 alone, 6 words 8'h10..8'h15, `full`=0 → `grant_id`=1 from cycle 1. `w_en` on 6 consecutive cycles, data in order, re-grant with no bubble after word 4.
- All four valid continuously → owner sequence 0×4, 1×4, 2×4, 3×4, then 0. `w_en` never deasserts.
- `full`=1 for 3 cycles after the 2nd word of a burst → `w_en`=0 and `req_ready`=0 for those cycles; `grant_id` unchanged. The remaining 2 words complete the burst.
- Owner 0 drops `req_valid` after 2 words while 2 and 3 are valid → 1 bubble, then `grant_id`=2, `rr_ptr`=1.
- `wrst_n` low mid-burst → `w_en`, `req_ready`, `busy` drop the same instant. After release: ARB_IDLE, `rr_ptr`=0, first grant to the lowest valid index.
- `FIFO_ARB_STATS_EN` build, scenario 1 repeated → `grant_cnt[1]`=6, others 0. With 70000 writes forced, the counter reads 16'hFFFF.
